// File: rtl/otter_pipe_pkg.sv
// Shared types and default parameters for the OTTER pipeline stall controller.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } stall_state_t;

  localparam int unsigned DEF_DRAIN_CYCLES = 4;
  localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Resolves freeze/redirect/load-use/fetch-wait priority into pipeline write and
// bubble controls, and runs the debug halt/drain state machine.
module pipeline_stall_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             halt_req,
  input  logic             clr_cnt,
  output logic             PC_write,
  output logic             if_de_write,
  output logic             de_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_de_flush,
  output logic             de_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  stall_state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halted_q;
  logic          stall_inc, flush_inc, cnt_clr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= RUN;
      drain_q  <= DW'(DRAIN_CYCLES);
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Outputs stay low while reset is held or memory freezes the whole pipe.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    PC_write     = 1'b0;
    if_de_write  = 1'b0;
    de_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_de_flush  = 1'b0;
    de_ex_flush  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (RST_N && !dmem_busy) begin
      unique case (state_q)
        RUN: begin
          if (halt_req) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          // A load-use bubble does not advance the drain; a redirect does.
          if (!(load_use && !br_taken)) begin
            drain_d = drain_q - DW'(1);
            if (drain_q == DW'(1)) begin
              state_d = HALTED;
            end
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (state_q != HALTED) begin
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        de_ex_write  = 1'b1;
        if (br_taken) begin
          PC_write    = 1'b1;
          if_de_write = 1'b1;
          if_de_flush = 1'b1;
          de_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          de_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (imem_busy || (state_q == DRAIN)) begin
          if_de_write = 1'b1;
          if_de_flush = 1'b1;
        end else begin
          PC_write    = 1'b1;
          if_de_write = 1'b1;
        end
      end
    end
  end

  assign cnt_clr = clr_cnt && !dmem_busy;
  assign halted  = halted_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (cnt_clr),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (cnt_clr),
    .inc   (flush_inc),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios then random traffic
// against a cycle-level reference model of the priority and halt rules.
module tb_pipeline_stall_ctrl;

  localparam int unsigned DRAIN = 4;
  localparam int unsigned CW    = 2;
  localparam int          SAT   = (1 << CW) - 1;

  typedef struct packed {
    logic          pc;
    logic          ifde;
    logic          deex;
    logic          exmem;
    logic          memwb;
    logic          ifde_f;
    logic          deex_f;
    logic          hlt;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          load_use = 1'b0, br_taken = 1'b0, imem_busy = 1'b0;
  logic          dmem_busy = 1'b0, halt_req = 1'b0, clr_cnt = 1'b0;
  logic          PC_write, if_de_write, de_ex_write, ex_mem_write, mem_wb_write;
  logic          if_de_flush, de_ex_flush, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_stall_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .load_use     (load_use),
    .br_taken     (br_taken),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .halt_req     (halt_req),
    .clr_cnt      (clr_cnt),
    .PC_write     (PC_write),
    .if_de_write  (if_de_write),
    .de_ex_write  (de_ex_write),
    .ex_mem_write (ex_mem_write),
    .mem_wb_write (mem_wb_write),
    .if_de_flush  (if_de_flush),
    .de_ex_flush  (de_ex_flush),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, n_push = 0, n_pop = 0;

  // Reference model: "draining" with cycles left, halted flag, plain counters.
  bit m_draining, m_halted;
  int m_left, m_sc, m_fc;

  function automatic void model_reset();
    m_draining = 0; m_halted = 0; m_left = DRAIN; m_sc = 0; m_fc = 0;
  endfunction

  function automatic exp_t model_out(bit rst_n, bit lu, bit br, bit im, bit dm);
    exp_t e = '0;
    if (!rst_n) return e;
    e.hlt = m_halted;
    e.sc  = CW'(m_sc);
    e.fc  = CW'(m_fc);
    if (dm || m_halted) return e;
    {e.deex, e.exmem, e.memwb} = 3'b111;
    if (br) begin
      {e.pc, e.ifde, e.ifde_f, e.deex_f} = 4'b1111;
    end else if (lu) begin
      e.deex_f = 1'b1;
    end else if (im || m_draining) begin
      {e.ifde, e.ifde_f} = 2'b11;
    end else begin
      {e.pc, e.ifde} = 2'b11;
    end
    return e;
  endfunction

  function automatic void model_step(bit lu, bit br, bit dm, bit hr, bit clr);
    bit was_halted = m_halted;
    if (dm) return;
    if (clr) begin
      m_sc = 0; m_fc = 0;
    end else if (!was_halted) begin
      if (br) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
      else if (lu) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
    end
    if (was_halted) begin
      if (!hr) m_halted = 0;
    end else if (m_draining) begin
      if (!(lu && !br)) begin
        if (m_left == 1) begin
          m_draining = 0; m_halted = 1;
        end
        m_left = m_left - 1;
      end
    end else if (hr) begin
      m_draining = 1; m_left = DRAIN;
    end
  endfunction

  task automatic cycle(input bit lu, input bit br, input bit im, input bit dm,
                       input bit hr, input bit clr);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    load_use = lu; br_taken = br; imem_busy = im;
    dmem_busy = dm; halt_req = hr; clr_cnt = clr;
    exp_q.push_back(model_out(1'b1, lu, br, im, dm));
    n_push++;
    model_step(lu, br, dm, hr, clr);
  endtask

  task automatic rst_cycle();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    load_use = 1'($urandom); br_taken = 1'($urandom); imem_busy = 1'($urandom);
    dmem_busy = 1'b0; halt_req = 1'($urandom); clr_cnt = 1'b0;
    model_reset();
    exp_q.push_back(model_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    n_push++;
  endtask

  // Monitor: compare every presented cycle against the oldest queued expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      n_pop++;
      g = '{PC_write, if_de_write, de_ex_write, ex_mem_write, mem_wb_write,
            if_de_flush, de_ex_flush, halted, stall_cnt, flush_cnt};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h (pc,ifde,deex,exmem,memwb,ifdef,deexf,halted,sc,fc)",
                 $time, g, e);
      end
    end
  end

  initial begin
    bit hr;
    model_reset();
    rst_cycle(); rst_cycle();
    cycle(0,0,0,0,0,0); cycle(0,0,0,0,0,0);
    // load-use in RUN, then branch with load-use
    cycle(1,0,0,0,0,0); cycle(0,0,0,0,0,0);
    cycle(1,1,0,0,0,0); cycle(0,0,0,0,0,0);
    // freeze during load-use, then the one bubble
    repeat (3) cycle(1,0,0,1,0,0);
    cycle(1,0,0,0,0,0); cycle(0,0,0,0,0,0);
    // halt and resume
    repeat (7) cycle(0,0,0,0,1,0);
    repeat (2) cycle(0,0,0,0,0,0);
    // halt_req pulse: drain completes, then resumes
    cycle(0,0,0,0,1,0);
    repeat (6) cycle(0,0,0,0,0,0);
    // saturation and clear
    repeat (5) begin cycle(1,0,0,0,0,0); cycle(0,0,0,0,0,0); end
    cycle(1,0,0,0,0,1); cycle(0,0,0,0,0,0);
    // reset mid-drain
    repeat (2) cycle(0,0,0,0,1,0);
    rst_cycle();
    repeat (2) cycle(0,0,0,0,0,0);
    // random traffic
    hr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hr = ~hr;
      if ($urandom_range(0, 199) == 0) rst_cycle();
      else cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12,
                 hr, $urandom_range(0, 99) < 3);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    n_cmp++;
    if (n_pop != n_push) begin
      n_err++;
      $display("FAIL scoreboard_drain popped=%0d pushed=%0d", n_pop, n_push);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline control block for the 5-stage OTTER core that consumes hazard and memory-wait requests and drives every pipeline-register write enable and bubble-insert signal. It receives the load-use request from the decode-stage hazard detector, the branch-taken redirect from EX, and the instruction/data memory busy handshakes. It resolves their priority, runs a debug halt/drain state machine, and keeps saturating stall and flush statistics.

## Interface
- DRAIN_CYCLES, 4: non-frozen, non-stalled cycles needed to empty DE..WB after fetch stops.
- CNT_W, 16: width of each statistics counter.
- CLK  in  1  core clock.
- RST_N  in  1  asynchronous, active-low reset. There is one clock. Reset is asynchronous and active-low.
- load_use  in  1  load-use hazard request from the hazard detector (DE depends on a load in EX).
- br_taken  in  1  branch/jump resolved taken in EX this cycle.
- imem_busy  in  1  instruction memory cannot return an instruction this cycle.
- dmem_busy  in  1  data memory access in MEM has not completed.
- halt_req  in  1  level-sensitive debug halt request.
- clr_cnt  in  1  synchronous clear of both counters.
- PC_write  out  1  PC register enable.
- if_de_write, de_ex_write, ex_mem_write, mem_wb_write  out  1 each  pipeline register enables.
- if_de_flush, de_ex_flush  out  1 each  load a NOP bubble into that register. Only meaningful when its write is 1.
- halted  out  1  pipeline empty and frozen.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  branch flush events, saturating.

## Operation
- States: RUN, DRAIN, HALTED. Reset state is RUN. The drain counter resets to DRAIN_CYCLES.
- Action priority each cycle, highest first:
  - **Freeze** (dmem_busy=1): all writes 0, flushes 0. No state or counter changes; the DRAIN countdown holds.
  - **HALTED**: all writes 0, flushes 0.
  - **Redirect** (br_taken=1): PC_write=1, all register writes 1, if_de_flush=1, de_ex_flush=1. A simultaneous load_use is ignored because it comes from a wrong-path instruction. flush_cnt increments.
  - **Load-use** (load_use=1): PC_write=0, if_de_write=0, de_ex_write=1 with de_ex_flush=1, ex_mem_write=1, mem_wb_write=1. stall_cnt increments.
  - **Fetch wait** (imem_busy=1, or state DRAIN): PC_write=0, if_de_write=1 with if_de_flush=1. Downstream registers are written.
  - **Normal**: all writes 1, flushes 0.
- RUN→DRAIN when halt_req=1 in a non-freeze cycle. The drain counter loads DRAIN_CYCLES.
- In DRAIN, the counter decrements only in cycles that are not a freeze and not a load-use stall. A redirect in DRAIN still writes PC so that resume fetches the branch target. The redirect cycle itself does count.
- DRAIN→HALTED when the counter is 1 and decrements. halted=1 is registered and asserts in the first HALTED cycle.
- HALTED→RUN when halt_req=0. halted drops in the same transition.
- halt_req falling during DRAIN completes the drain anyway, then takes HALTED→RUN on the next cycle.
- Counters saturate at 2^CNT_W−1. clr_cnt has priority over increment.

## Timing
- All write and flush outputs are combinational from the state and the current inputs, with zero-cycle latency.
- State, drain counter, halted and the statistics counters update on the CLK rising edge.
- While RST_N=0:
  - all *_write=0, all *_flush=0;
  - halted=0, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-DRAIN or HALTED returns to RUN immediately and asynchronously.
- Minimum halt latency is DRAIN_CYCLES+1 cycles from halt_req rising to halted=1, with no freezes or stalls.
- A single load_use pulse yields exactly one bubble. The hazard detector is responsible for deasserting it once the load moves to MEM.

## Structure
- Put these in the shared package otter_pipe_pkg:
  - the typedef enum stall_state_t {RUN, DRAIN, HALTED};
  - the localparam defaults for DRAIN_CYCLES and CNT_W.
- Sub-module sat_counter (params W; ports CLK, RST_N, clr, inc, q) is instantiated twice, once for stall_cnt and once for flush_cnt.

## Test plan
- **Load-use in RUN:** load_use=1 for one cycle → that cycle PC_write=0, if_de_write=0, de_ex_flush=1. Next cycle all writes 1. stall_cnt=1.
- **Branch and load-use together:** br_taken=1 with load_use=1 → PC_write=1, if_de_flush=1, de_ex_flush=1. flush_cnt=1 and stall_cnt unchanged.
- **Data-memory freeze:** dmem_busy=1 for 3 cycles during load_use=1 → all writes 0 for those 3 cycles and stall_cnt unchanged. Then one load-use bubble follows after dmem_busy drops.
- **Halt and resume:** halt_req rises with DRAIN_CYCLES=4 and no hazards → if_de_flush=1 for 4 cycles, halted=1 on cycle 5 with all writes 0. Dropping halt_req gives RUN next cycle with halted=0.
- **Saturation and clear:** CNT_W=2, 5 load-use pulses → stall_cnt=3. Then clr_cnt=1 together with load_use=1 → stall_cnt=0.
- **Reset mid-drain:** RST_N low mid-DRAIN → outputs go to reset values immediately. After release, state is RUN, halted=0, and all writes are 1.
